// File: rtl/sin_cos_pkg.sv
// Shared widths, FSM state encoding and quadrant codes for the sine/cosine scheduler.
package sin_cos_pkg;
  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 7;
  localparam int FRAC_W  = 7;
  localparam int C0_W    = 19;
  localparam int C1_W    = 12;
  localparam int OUT_W   = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    EVAL_B  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;
endpackage

// File: rtl/sin_cos_eval.sv
// Combinational first-order segment evaluation: c0 + ((c1 * x) >>> 7), clamped or wrapped to 19 bits.
module sin_cos_eval
  import sin_cos_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        [C0_W-1:0]   c0,
  input  logic signed [C1_W-1:0]   c1,
  input  logic        [FRAC_W-1:0] x,
  output logic        [C0_W-1:0]   mag
);
  localparam int PROD_W = C1_W + FRAC_W + 1;
  localparam int SUM_W  = C0_W + 2;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [SUM_W-1:0]  shifted_ext;
  logic signed [SUM_W-1:0]  sum;

  function automatic logic [C0_W-1:0] sat_mag(input logic signed [SUM_W-1:0] s);
    logic [C0_W-1:0] res;
    res = s[C0_W-1:0];
    if (SAT_EN) begin
      if (s[SUM_W-1])
        res = '0;
      else if (s[SUM_W-2:C0_W] != '0)
        res = '1;
    end
    return res;
  endfunction

  // The product fits in 19 signed bits; one spare bit keeps the sign-extension explicit.
  always_comb begin
    prod        = $signed({{(PROD_W-C1_W){c1[C1_W-1]}}, c1}) * $signed({{(PROD_W-FRAC_W){1'b0}}, x});
    shifted     = prod >>> FRAC_W;
    shifted_ext = {shifted[PROD_W-1], shifted};
    sum         = $signed({2'b00, c0}) + shifted_ext;
    mag         = sat_mag(sum);
  end
endmodule

// File: rtl/sin_cos_sched.sv
// Sequences two ROM lookups per phase sample (segment s and its mirror ~s) and folds them into signed sin/cos.
module sin_cos_sched
  import sin_cos_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [PHASE_W-1:0] phase,
  output logic        [ADDR_W-1:0]  rom_addr,
  input  logic        [C0_W-1:0]    rom_c0,
  input  logic signed [C1_W-1:0]    rom_c1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   sin_out,
  output logic signed [OUT_W-1:0]   cos_out
);
  state_e                    state_q, state_d;
  logic [PHASE_W-1:0]        phase_q;
  logic                      phase_ld;
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic [C0_W-1:0]           a_q, a_d;
  logic signed [OUT_W-1:0]   sin_q, sin_d, cos_q, cos_d;
  logic                      out_valid_q, out_valid_d;

  logic [1:0]                quad;
  logic [ADDR_W-1:0]         seg;
  logic [FRAC_W-1:0]         frac, eval_x;
  logic [C0_W-1:0]           eval_mag;
  logic signed [OUT_W-1:0]   pos_a, neg_a, pos_b, neg_b;

  assign quad = phase_q[15:14];
  assign seg  = phase_q[13:7];
  assign frac = phase_q[6:0];

  // Segment A uses f, mirrored segment B uses ~f; one evaluator serves both cycles.
  assign eval_x = (state_q == EVAL_B) ? ~frac : frac;

  sin_cos_eval #(.SAT_EN(SAT_EN)) u_eval (
    .c0  (rom_c0),
    .c1  (rom_c1),
    .x   (eval_x),
    .mag (eval_mag)
  );

  assign pos_a = $signed({1'b0, a_q});
  assign neg_a = -pos_a;
  assign pos_b = $signed({1'b0, eval_mag});
  assign neg_b = -pos_b;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    a_d         = a_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    phase_ld    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          phase_ld   = 1'b1;
          rom_addr_d = phase[13:7];
          state_d    = FETCH_A;
        end
      end
      FETCH_A: begin
        rom_addr_d = ~seg;
        state_d    = FETCH_B;
      end
      FETCH_B: begin
        a_d     = eval_mag;
        state_d = EVAL_B;
      end
      EVAL_B: begin
        unique case (quad)
          QUAD_0:  begin sin_d = pos_a; cos_d = pos_b; end
          QUAD_1:  begin sin_d = pos_b; cos_d = neg_a; end
          QUAD_2:  begin sin_d = neg_a; cos_d = neg_b; end
          default: begin sin_d = neg_b; cos_d = pos_a; end
        endcase
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      a_q         <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      a_q         <= a_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (phase_ld)
      phase_q <= phase;
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
endmodule

// File: tb/tb_sin_cos_sched.sv
// Bench for sin_cos_sched: synchronous ROM model, arithmetic reference for sin/cos, handshake and reset scenarios.
module tb_sin_cos_sched;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        phase = '0;
  logic [6:0]         rom_addr;
  logic [18:0]        rom_c0 = '0;
  logic signed [11:0] rom_c1 = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [19:0] sin_out;
  logic signed [19:0] cos_out;

  int tb_c0 [128];
  int tb_c1 [128];
  int n_checks = 0;
  int n_fail   = 0;

  sin_cos_sched #(.SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .phase     (phase),
    .rom_addr  (rom_addr),
    .rom_c0    (rom_c0),
    .rom_c1    (rom_c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sin_out   (sin_out),
    .cos_out   (cos_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_c0 <= 19'(tb_c0[rom_addr]);
    rom_c1 <= 12'(tb_c1[rom_addr]);
  end

  function automatic int ref_s(input int c0, input int c1, input int x);
    int sum;
    sum = c0 + ((c1 * x) >>> 7);
    if (sum < 0) sum = 0;
    if (sum > 524287) sum = 524287;
    return sum;
  endfunction

  // sin/cos of (q * 90deg + theta): A is the sine of theta, B its complement read from the mirrored segment.
  task automatic model(input logic [15:0] ph, output logic signed [19:0] es, output logic signed [19:0] ec);
    int q, s, f, a, b;
    q = int'(ph[15:14]);
    s = int'(ph[13:7]);
    f = int'(ph[6:0]);
    a = ref_s(tb_c0[s], tb_c1[s], f);
    b = ref_s(tb_c0[127 - s], tb_c1[127 - s], 127 - f);
    case (q)
      0:       begin es = 20'(a);  ec = 20'(b);  end
      1:       begin es = 20'(b);  ec = 20'(-a); end
      2:       begin es = 20'(-a); ec = 20'(-b); end
      default: begin es = 20'(-b); ec = 20'(a);  end
    endcase
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 128; i++) begin
      tb_c0[i] = int'($urandom_range(0, 524287));
      tb_c1[i] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  task automatic accept(input logic [15:0] ph);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    phase    = ph;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    phase    = 16'($urandom);
  endtask

  task automatic run_txn(input logic [15:0] ph, input string tag);
    logic signed [19:0] es, ec;
    int lat;
    model(ph, es, ec);
    accept(ph);
    n_checks++;
    if (rom_addr !== ph[13:7]) begin
      n_fail++;
      $display("FAIL %s addr_a: rom_addr=%0d required %0d", tag, rom_addr, ph[13:7]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rom_addr !== 7'(127 - int'(ph[13:7]))) begin
      n_fail++;
      $display("FAIL %s addr_b: rom_addr=%0d required %0d", tag, rom_addr, 127 - int'(ph[13:7]));
    end
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== 3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: edges=%0d out_valid=%b required 3 and 1", tag, lat, out_valid);
    end
    n_checks++;
    if (sin_out !== es || cos_out !== ec) begin
      n_fail++;
      $display("FAIL %s value ph=%h: sin=%0d cos=%0d required sin=%0d cos=%0d", tag, ph, sin_out, cos_out, es, ec);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0 and 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sin_out !== 20'sd0 || cos_out !== 20'sd0 || rom_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sin=%0d cos=%0d addr=%0d required 1 0 0 0 0",
               in_ready, out_valid, sin_out, cos_out, rom_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed_phases();
    run_txn(16'h0000, "phase0000");
    run_txn(16'h4000, "phase4000");
    n_checks++;
    if (tb_c0[0] != 0 && cos_out[19] !== 1'b1) begin
      n_fail++;
      $display("FAIL phase4000_sign: cos_out=%0d required negative", cos_out);
    end
    run_txn(16'hFFFF, "phaseFFFF");
    run_txn(16'h8000, "phase8000");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) fill_rom();
      run_txn(16'($urandom), "random");
    end
  endtask

  task automatic test_saturation();
    tb_c0[5] = 524287;
    tb_c1[5] = 2047;
    run_txn({2'b00, 7'd5, 7'd127}, "sat_high");
    n_checks++;
    if (sin_out !== 20'sd524287) begin
      n_fail++;
      $display("FAIL sat_high_const: sin=%0d required 524287", sin_out);
    end
    tb_c0[5] = 0;
    tb_c1[5] = -2048;
    run_txn({2'b00, 7'd5, 7'd127}, "sat_low");
    n_checks++;
    if (sin_out !== 20'sd0) begin
      n_fail++;
      $display("FAIL sat_low_const: sin=%0d required 0", sin_out);
    end
  endtask

  task automatic test_backpressure();
    logic signed [19:0] es, ec;
    logic [15:0] ph;
    int lat;
    ph = 16'($urandom);
    model(ph, es, ec);
    accept(ph);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      phase    = ~ph;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sin_out !== es || cos_out !== ec ||
          rom_addr !== 7'(127 - int'(ph[13:7]))) begin
        n_fail++;
        $display("FAIL backpressure_hold c=%0d: vld=%b rdy=%b sin=%0d cos=%0d addr=%0d required 1 0 %0d %0d %0d",
                 c, out_valid, in_ready, sin_out, cos_out, rom_addr, es, ec, 127 - int'(ph[13:7]));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 and 1", out_valid, in_ready);
    end
    run_txn(16'($urandom), "after_bp");
  endtask

  task automatic test_reset_midflight();
    accept(16'($urandom));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sin_out !== 20'sd0 || cos_out !== 20'sd0 || rom_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL midflight_reset: vld=%b rdy=%b sin=%0d cos=%0d addr=%0d required 0 1 0 0 0",
               out_valid, in_ready, sin_out, cos_out, rom_addr);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_release: in_ready=%b out_valid=%b required 1 and 0", in_ready, out_valid);
    end
    run_txn(16'($urandom), "after_reset");
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_fixed_phases();
    test_random();
    test_saturation();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sin_cos_sched.md
SIN_COS_SCHED -- requirements
Module: sin_cos_sched

Interface
REQ-001 SHALL have parameter SAT_EN, default 1, meaning: clamp polynomial result to [0, 2^19-1] when 1, otherwise truncate to 19 bits when 0.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, phase sample offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept a phase sample.
REQ-006 SHALL have port phase, input, 16, unsigned phase: [15:14] quadrant q, [13:7] segment s, [6:0] fraction f.
REQ-007 SHALL have port rom_addr, output, 7, registered address to the external 128-entry sine coefficient ROM.
REQ-008 SHALL have port rom_c0, input, 19, unsigned c0 from the ROM, valid one clock after the address is presented.
REQ-009 SHALL have port rom_c1, input, 12, signed two's-complement c1 from the ROM, with the same timing as rom_c0.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port sin_out, output, 20, signed sine result.
REQ-013 SHALL have port cos_out, output, 20, signed cosine result.

Function
REQ-014 SHALL implement the states IDLE, FETCH_A, FETCH_B, EVAL_B and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; in_ready is decoded combinationally from the state.
REQ-016 SHALL, on the edge where in_valid & in_ready, latch phase, load rom_addr <= s, and go to FETCH_A.
REQ-017 SHALL, in FETCH_A, on the next edge load rom_addr <= ~s and go to FETCH_B.
REQ-018 SHALL, in FETCH_B, on the next edge register A = S(rom_c0, rom_c1, f) and go to EVAL_B.
REQ-019 SHALL, in EVAL_B, on the next edge compute B = S(rom_c0, rom_c1, ~f), register sin_out/cos_out, set out_valid = 1, and go to DONE.
REQ-020 SHALL define the polynomial as S(c0, c1, x) = c0 + sign-extend((c1 * x) >>> 7), with c1 * x a 19-bit signed product, x unsigned 7-bit, and the sum formed at 21-bit signed width.
REQ-021 SHALL saturate the sum per SAT_EN: with SAT_EN=1, sums < 0 give 0 and sums > 2^19-1 give 2^19-1; with SAT_EN=0, keep the low 19 bits.
REQ-022 SHALL map quadrants as follows: q=0 gives sin=+A, cos=+B; q=1 gives sin=+B, cos=-A; q=2 gives sin=-A, cos=-B; q=3 gives sin=-B, cos=+A.
REQ-023 SHALL zero-extend magnitudes to 20 bits before any negation, so that no overflow is possible.
REQ-024 SHALL, in DONE, hold out_valid, sin_out and cos_out stable until out_ready = 1.
REQ-025 SHALL, on the edge where out_valid & out_ready, clear out_valid and go to IDLE.
REQ-026 SHALL have a latency of 3 edges from the accepting edge to out_valid = 1.
REQ-027 SHALL have a minimum spacing of 5 cycles between accepts.
REQ-028 SHALL keep in_ready = 0 in DONE, so that no accept coincides with the output handshake.
REQ-029 SHALL hold rom_addr at its last value in IDLE and in DONE.
REQ-030 SHALL ignore in_valid outside IDLE; phase is not re-sampled.
REQ-031 SHALL ignore out_ready outside DONE.

Reset
REQ-032 SHALL, on rst = 1, force state = IDLE and set out_valid, sin_out, cos_out, rom_addr and the A register to 0, independent of clk.
REQ-033 SHALL abandon any in-flight sample on reset mid-operation, leave no partial output, and assert in_ready in the first cycle after rst is released.
REQ-034 SHALL NOT depend on rom_c0/rom_c1 contents during or immediately after reset.

Structure
REQ-035 SHALL place the following in shared package sin_cos_pkg: widths (PHASE_W=16, ADDR_W=7, FRAC_W=7, C0_W=19, C1_W=12, OUT_W=20), the state enumeration, and the quadrant encoding constants.
REQ-036 SHALL implement the multiply-add-saturate as combinational sub-module sin_cos_eval (inputs c0, c1, x; output 19-bit magnitude), instantiated once and shared between the A and B evaluations.
REQ-037 SHALL instantiate the coefficient ROM at the level above, not inside this block.

Verification
REQ-038 SHALL cover: phase=0x0000, ROM model in place -> rom_addr 0 then 127; sin_out=+S(c0[0],c1[0],0); cos_out=+S(c0[127],c1[127],127); out_valid exactly 3 edges after the accept.
REQ-039 SHALL cover: phase=0x4000 -> sin_out=+S(entry127,127), cos_out=-S(entry0,0); sign bit of cos_out = 1.
REQ-040 SHALL cover: phase=0xFFFF (q=3, s=127, f=127) -> sin_out=-S(entry0,0), cos_out=+S(entry127,127).
REQ-041 SHALL cover: ROM model forcing c0=2^19-1, c1=+2047, f=127, SAT_EN=1 -> magnitude 524287; same with c0=0, c1=-2048 -> magnitude 0.
REQ-042 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, second in_valid not accepted; then out_ready=1 -> out_valid=0 next edge and in_ready=1.
REQ-043 SHALL cover: rst pulsed while in FETCH_B -> out_valid stays 0, state IDLE, all outputs 0; a new sample is accepted on the first cycle after release.
